// File: rtl/ex_operand_stage.sv
// ex_operand_stage: DLX execute-stage operand selector.
// Decodes the incoming 7-bit control word at accept time and steers register,
// sign-extended immediate or shift-amount operands to the ALU. Valid/ready
// flow control uses an output register backed by one skid register, so
// in_ready can be registered without losing words.
// Optional feature macro: FWD_EN (write-back forwarding onto rs1/rs2).
module ex_operand_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         control_in,
  input  logic [IMM_W-1:0]   imm,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
`ifdef FWD_EN
  input  logic [ADDR_W-1:0]  rs1_addr,
  input  logic [ADDR_W-1:0]  rs2_addr,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         operation,
  output logic [2:0]         opselect,
  output logic [DATA_W-1:0]  aluin1,
  output logic [DATA_W-1:0]  aluin2,
  output logic [SHAMT_W-1:0] shift_number,
  output logic               enable_arith,
  output logic               enable_shift
);

  localparam logic [2:0] OpShiftReg   = 3'b000;
  localparam logic [2:0] OpArithLogic = 3'b001;
  localparam logic [2:0] OpMemRead    = 3'b101;

  typedef struct packed {
    logic [2:0]         operation;
    logic [2:0]         opselect;
    logic [DATA_W-1:0]  aluin1;
    logic [DATA_W-1:0]  aluin2;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               shift;
  } word_t;

  logic               accept;
  logic               drain;
  logic [DATA_W-1:0]  rs1_eff;
  logic [DATA_W-1:0]  rs2_eff;
  logic [DATA_W-1:0]  imm_sext;
  word_t              dec_word;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  word_t              out_word_q, out_word_d;
  logic               skid_valid_q, skid_valid_d;
  word_t              skid_word_q, skid_word_d;
  logic [DATA_W-1:0]  last_aluin2_q;
  logic [SHAMT_W-1:0] last_shamt_q;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Source operand selection, with optional write-back forwarding.
`ifdef FWD_EN
  always_comb begin
    rs1_eff = rs1_data;
    rs2_eff = rs2_data;
    if (wb_valid && (wb_addr != '0)) begin
      if (wb_addr == rs1_addr) rs1_eff = wb_data;
      if (wb_addr == rs2_addr) rs2_eff = wb_data;
    end
  end
`else
  logic [ADDR_W-1:0] unused_addr;
  assign unused_addr = '0;
  assign rs1_eff = rs1_data;
  assign rs2_eff = rs2_data;
`endif

  // Sign-extend the immediate; upper fill is overwritten when widths match.
  always_comb begin
    imm_sext = {DATA_W{imm[IMM_W-1]}};
    imm_sext[IMM_W-1:0] = imm;
  end

  // Decode the current control word; unselected fields carry the previous word's values.
  always_comb begin
    dec_word.operation = control_in[6:4];
    dec_word.opselect  = control_in[2:0];
    dec_word.aluin1    = rs1_eff;
    dec_word.aluin2    = last_aluin2_q;
    dec_word.shamt     = last_shamt_q;
    dec_word.arith     = 1'b0;
    dec_word.shift     = 1'b0;
    case (control_in[2:0])
      OpArithLogic: begin
        dec_word.aluin2 = control_in[3] ? imm_sext : rs2_eff;
        dec_word.arith  = 1'b1;
      end
      OpMemRead: begin
        if (control_in[3]) begin
          dec_word.aluin2 = rs2_eff;
          dec_word.arith  = 1'b1;
        end
      end
      OpShiftReg: begin
        dec_word.shift = 1'b1;
        dec_word.shamt = imm[2] ? rs2_eff[SHAMT_W-1:0] : imm[6+SHAMT_W-1:6];
      end
      default: ;
    endcase
  end

  // Output/skid next state: skid fills only when the output register is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    if (skid_valid_q) begin
      // in_ready is low here, so no accept can coincide.
      if (drain) begin
        out_word_d   = skid_word_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        out_word_d  = dec_word;
      end else begin
        skid_valid_d = 1'b1;
        skid_word_d  = dec_word;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_word_q    <= '0;
      skid_valid_q  <= 1'b0;
      skid_word_q   <= '0;
      last_aluin2_q <= '0;
      last_shamt_q  <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
      if (accept) begin
        last_aluin2_q <= dec_word.aluin2;
        last_shamt_q  <= dec_word.shamt;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign operation    = out_word_q.operation;
  assign opselect     = out_word_q.opselect;
  assign aluin1       = out_word_q.aluin1;
  assign aluin2       = out_word_q.aluin2;
  assign shift_number = out_word_q.shamt;
  assign enable_arith = out_word_q.arith & out_valid_q;
  assign enable_shift = out_word_q.shift & out_valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage: a vector table for decode, plus
// hand-written sequences for skid back-pressure and mid-stream reset.
module tb_ex_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  control_in;
  logic [15:0] imm;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
`ifdef FWD_EN
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  operation;
  logic [2:0]  opselect;
  logic [15:0] aluin1;
  logic [15:0] aluin2;
  logic [4:0]  shift_number;
  logic        enable_arith;
  logic        enable_shift;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ex_operand_stage dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .control_in   (control_in),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
`ifdef FWD_EN
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .operation    (operation),
    .opselect     (opselect),
    .aluin1       (aluin1),
    .aluin2       (aluin2),
    .shift_number (shift_number),
    .enable_arith (enable_arith),
    .enable_shift (enable_shift)
  );

  typedef struct {
    logic [6:0]  ctrl;
    logic [15:0] imm;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic [15:0] exp_a1;
    logic [15:0] exp_a2;
    logic [4:0]  exp_sh;
    logic        exp_ar;
    logic        exp_sf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] c, input logic [15:0] i, input logic [15:0] r1,
                       input logic [15:0] r2);
    in_valid   = 1'b1;
    control_in = c;
    imm        = i;
    rs1_data   = r1;
    rs2_data   = r2;
  endtask

  initial begin
    // {operation, imm_sel, opselect}
    vecs[0] = '{7'b010_1_001, 16'hFFF0, 16'h0005, 16'h1111, 16'h0005, 16'hFFF0, 5'd0,  1, 0};
    vecs[1] = '{7'b001_0_001, 16'h0000, 16'h00A0, 16'h7777, 16'h00A0, 16'h7777, 5'd0,  1, 0};
    vecs[2] = '{7'b101_0_000, 16'h0240, 16'h1000, 16'hFFFF, 16'h1000, 16'h7777, 5'd9,  0, 1};
    vecs[3] = '{7'b110_0_000, 16'h0004, 16'h1001, 16'h0013, 16'h1001, 16'h7777, 5'd19, 0, 1};
    vecs[4] = '{7'b000_1_101, 16'h0008, 16'h2222, 16'h1234, 16'h2222, 16'h1234, 5'd19, 1, 0};
    vecs[5] = '{7'b011_0_101, 16'h0000, 16'h3333, 16'hBEEF, 16'h3333, 16'h1234, 5'd19, 0, 0};
    vecs[6] = '{7'b111_1_011, 16'h0FC0, 16'h4444, 16'h5555, 16'h4444, 16'h1234, 5'd19, 0, 0};
    vecs[7] = '{7'b010_1_001, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h7FFF, 5'd19, 1, 0};
    vecs[8] = '{7'b010_1_001, 16'h8000, 16'hFFFF, 16'h0002, 16'hFFFF, 16'h8000, 5'd19, 1, 0};
    vecs[9] = '{7'b100_0_000, 16'h0FC0, 16'h0101, 16'h0000, 16'h0101, 16'h8000, 5'd31, 0, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    control_in = '0; imm = '0; rs1_data = '0; rs2_data = '0;
`ifdef FWD_EN
    rs1_addr = '0; rs2_addr = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
`endif
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_aluin1", {16'd0, aluin1}, 32'd0);
    check("rst_aluin2", {16'd0, aluin2}, 32'd0);
    check("rst_shift_number", {27'd0, shift_number}, 32'd0);
    check("rst_operation", {29'd0, operation}, 32'd0);
    check("rst_opselect", {29'd0, opselect}, 32'd0);
    check("rst_enables", {30'd0, enable_arith, enable_shift}, 32'd0);
    reset = 1'b0;

    // Back-to-back decode with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ctrl, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
      tick();
      check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("v%0d_operation", i), {29'd0, operation}, {29'd0, vecs[i].ctrl[6:4]});
      check($sformatf("v%0d_opselect", i), {29'd0, opselect}, {29'd0, vecs[i].ctrl[2:0]});
      check($sformatf("v%0d_aluin1", i), {16'd0, aluin1}, {16'd0, vecs[i].exp_a1});
      check($sformatf("v%0d_aluin2", i), {16'd0, aluin2}, {16'd0, vecs[i].exp_a2});
      check($sformatf("v%0d_shift_number", i), {27'd0, shift_number}, {27'd0, vecs[i].exp_sh});
      check($sformatf("v%0d_enable_arith", i), {31'd0, enable_arith}, {31'd0, vecs[i].exp_ar});
      check($sformatf("v%0d_enable_shift", i), {31'd0, enable_shift}, {31'd0, vecs[i].exp_sf});
    end
    in_valid = 1'b0;
    tick();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_enables", {30'd0, enable_arith, enable_shift}, 32'd0);

    // Skid: A to output, B to skid, C held upstream, then drain in order.
    out_ready = 1'b0;
    drive(7'b000_0_001, 16'h0000, 16'h000A, 16'hA0A0);
    tick();
    drive(7'b000_0_001, 16'h0000, 16'h000B, 16'hB0B0);
    tick();
    drive(7'b000_0_001, 16'h0000, 16'h000C, 16'hC0C0);
    tick();
    check("skid_out_valid", {31'd0, out_valid}, 32'd1);
    check("skid_in_ready", {31'd0, in_ready}, 32'd0);
    check("skid_hold_a1", {16'd0, aluin1}, 32'h000A);
    tick();
    check("skid_stable_a1", {16'd0, aluin1}, 32'h000A);
    check("skid_stable_a2", {16'd0, aluin2}, 32'hA0A0);
    out_ready = 1'b1;
    tick();
    check("drain_b_a1", {16'd0, aluin1}, 32'h000B);
    check("drain_b_a2", {16'd0, aluin2}, 32'hB0B0);
    check("drain_b_valid", {31'd0, out_valid}, 32'd1);
    check("drain_b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("drain_c_a1", {16'd0, aluin1}, 32'h000C);
    check("drain_c_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain_done_valid", {31'd0, out_valid}, 32'd0);

    // Reset with output and skid both full.
    out_ready = 1'b0;
    drive(7'b000_0_001, 16'h0000, 16'h00D1, 16'hD1D1);
    tick();
    drive(7'b000_0_001, 16'h0000, 16'h00D2, 16'hD2D2);
    tick();
    check("prerst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_aluin1", {16'd0, aluin1}, 32'd0);
    check("midrst_aluin2", {16'd0, aluin2}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("postrst_out_valid2", {31'd0, out_valid}, 32'd0);

`ifdef FWD_EN
    // Forwarding onto rs1, no forwarding from x0, forwarding onto shift amount.
    rs1_addr = 5'd3; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 16'hCAFE;
    drive(7'b000_0_001, 16'h0000, 16'h0000, 16'h0001);
    tick();
    check("fwd_rs1_a1", {16'd0, aluin1}, 32'hCAFE);
    rs1_addr = 5'd0; wb_addr = 5'd0;
    drive(7'b000_0_001, 16'h0000, 16'h1357, 16'h0001);
    tick();
    check("fwd_x0_a1", {16'd0, aluin1}, 32'h1357);
    rs1_addr = 5'd1; rs2_addr = 5'd4; wb_addr = 5'd4; wb_data = 16'h0007;
    drive(7'b000_0_000, 16'h0004, 16'h0000, 16'h001F);
    tick();
    check("fwd_rs2_shamt", {27'd0, shift_number}, 32'd7);
    in_valid = 1'b0; wb_valid = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
